// File: rtl/deser_link_arbiter_if.sv
// deser_link_arbiter_if: requester-side byte bus plus the serial link pins
// toward the deserializer. The arbiter uses the slave modport; the driving
// environment (requesters plus the deserializer) uses the master modport.
interface deser_link_arbiter_if #(
    parameter int N_REQ = 2
);
    // Requester side
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done;
    logic [7:0]         rx_byte;

    // Deserializer side
    logic               ser_data;
    logic               ser_write;
    logic               deser_ready;
    logic [7:0]         deser_data;
    logic               deser_ack;

    // Status
    logic               busy;
    logic               err;

    modport slave (
        input  req,
        input  req_data,
        input  deser_ready,
        input  deser_data,
        output gnt,
        output done,
        output rx_byte,
        output ser_data,
        output ser_write,
        output deser_ack,
        output busy,
        output err
    );

    modport master (
        output req,
        output req_data,
        output deser_ready,
        output deser_data,
        input  gnt,
        input  done,
        input  rx_byte,
        input  ser_data,
        input  ser_write,
        input  deser_ack,
        input  busy,
        input  err
    );
endinterface

// File: rtl/deser_link_arbiter.sv
// deser_link_arbiter: round-robin scheduler sharing one serial deserializer
// link among N_REQ byte producers. A granted byte is shifted MSB-first as
// write/gap bit pairs, the reassembled byte is returned to its owner, and the
// deserializer is acknowledged.
// Optional feature macro: ARB_TIMEOUT_EN adds a WAIT_RDY watchdog of
// TIMEOUT_CYC cycles that pulses err and flushes the deserializer.
module deser_link_arbiter #(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clock_100,
    input  logic                reset,
    deser_link_arbiter_if.slave bus
);

    localparam int IW = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    // An illegal parameterisation never arbitrates, so it stays idle.
    localparam bit CFG_OK = (N_REQ >= 2) && (N_REQ <= 8) && (TIMEOUT_CYC >= 1);
    localparam logic [N_REQ-1:0] ONE_HOT_0 = N_REQ'(1);
    localparam logic [IW-1:0]    LAST_RST  = IW'(N_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SHIFT,
        GAP,
        WAIT_RDY,
        ACK,
        DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    last_q, last_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             ser_data_q, ser_data_d;
    logic             ser_write_q, ser_write_d;
    logic             deser_ack_q, deser_ack_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

`ifdef ARB_TIMEOUT_EN
    localparam int            TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0]            tmo_cnt_q, tmo_cnt_d;
`endif

    // Per-requester byte view of the flat request data bus
    logic [7:0] req_byte [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req_byte
            assign req_byte[gi] = bus.req_data[8*gi +: 8];
        end
    endgenerate

    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand_idx;

    // Round-robin winner search, starting one past the last served requester
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_idx = IW'((int'(last_q) + k) % N_REQ);
            if (!win_found && bus.req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next-state and registered-output computation for the link FSM
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        rx_byte_d   = rx_byte_q;
        gnt_d       = '0;
        done_d      = '0;
        ser_write_d = 1'b0;
        ser_data_d  = ser_data_q;
        deser_ack_d = 1'b0;
        err_d       = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (win_found && CFG_OK) begin
                    owner_d = win_idx;
                    shreg_d = req_byte[win_idx];
                    gnt_d   = ONE_HOT_0 << win_idx;
                    state_d = GRANT;
                end
            end

            GRANT: begin
                // First bit goes out on the way into SHIFT so it is already
                // on the wire while ser_write is high.
                last_d      = owner_q;
                bit_cnt_d   = 3'd7;
                ser_write_d = 1'b1;
                ser_data_d  = shreg_q[7];
                state_d     = SHIFT;
            end

            SHIFT: begin
                // ser_write drops by default; ser_data keeps its value.
                state_d = GAP;
            end

            GAP: begin
                if (bit_cnt_q == 3'd0) begin
                    state_d = WAIT_RDY;
`ifdef ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end else begin
                    bit_cnt_d   = bit_cnt_q - 3'd1;
                    ser_write_d = 1'b1;
                    ser_data_d  = shreg_q[bit_cnt_q - 3'd1];
                    state_d     = SHIFT;
                end
            end

            WAIT_RDY: begin
                if (bus.deser_ready) begin
                    rx_byte_d = bus.deser_data;
                    done_d    = ONE_HOT_0 << owner_q;
                    state_d   = ACK;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    // Give up: flag it and flush the deserializer, no done.
                    err_d       = 1'b1;
                    deser_ack_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end

            ACK: begin
                // Ack lands the cycle after done.
                deser_ack_d = 1'b1;
                state_d     = DRAIN;
            end

            DRAIN: begin
                if (!bus.deser_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            last_q      <= LAST_RST;
            shreg_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            gnt_q       <= '0;
            done_q      <= '0;
            rx_byte_q   <= 8'h00;
            ser_data_q  <= 1'b0;
            ser_write_q <= 1'b0;
            deser_ack_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rx_byte_q   <= rx_byte_d;
            ser_data_q  <= ser_data_d;
            ser_write_q <= ser_write_d;
            deser_ack_q <= deser_ack_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // WAIT_RDY watchdog counter
    always_ff @(posedge clock_100 or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.rx_byte   = rx_byte_q;
    assign bus.ser_data  = ser_data_q;
    assign bus.ser_write = ser_write_q;
    assign bus.deser_ack = deser_ack_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

endmodule

// File: doc/deser_link_arbiter.md
# deser_link_arbiter

Round-robin scheduler that shares one serial `deserializer` link among `N_REQ` byte producers. It accepts a byte from the winning requester and shifts it MSB-first onto the deserializer's `data_in`/`write_in` pins. It then waits for `data_ready`, returns the reassembled byte to the owner and acknowledges the deserializer via `ack_in`. It sits directly in front of the `deserializer` instance in the same clock domain.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters, 2..8.
- `TIMEOUT_CYC`, default 64: `WAIT_RDY` watchdog limit in cycles. Used only with `ARB_TIMEOUT_EN`.

Ports:
- `clock_100`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  N_REQ  per-requester byte request. Held with data stable until `gnt`.
- `req_data`  in  8*N_REQ  byte for requester i at bits [8i+7:8i].
- `gnt`  out  N_REQ  one-hot, 1-cycle pulse when the byte is latched.
- `done`  out  N_REQ  one-hot, 1-cycle pulse when `rx_byte` is valid for the owner.
- `rx_byte`  out  8  byte captured from the deserializer. Held until the next capture.
- `ser_data`  out  1  to deserializer `data_in`.
- `ser_write`  out  1  to deserializer `write_in`.
- `deser_ready`  in  1  from deserializer `data_ready`.
- `deser_data`  in  8  from deserializer `data_out`.
- `deser_ack`  out  1  to deserializer `ack_in`.
- `busy`  out  1  high in every state except `IDLE`.
- `err`  out  1  1-cycle timeout pulse. Tied 0 without `ARB_TIMEOUT_EN`.

## Operation
- States: `IDLE`, `GRANT`, `SHIFT`, `GAP`, `WAIT_RDY`, `ACK`, `DRAIN`.
- **IDLE:** if any `req` bit is high, select the winner round-robin, starting the search at `last+1` mod `N_REQ`. Latch `owner` and `req_data[owner]`, then go to `GRANT`. Reset value of `last` is `N_REQ-1`, so requester 0 wins first.
- **GRANT:** `gnt[owner]`=1 for one cycle. Set `last`=`owner` and `bit_cnt`=7. Go to `SHIFT`.
- **SHIFT:** `ser_write`=1, `ser_data`=`shreg[bit_cnt]`. Go to `GAP`.
- **GAP:** `ser_write`=0, `ser_data` holds its value. If `bit_cnt`==0, go to `WAIT_RDY`; otherwise decrement `bit_cnt` and go to `SHIFT`.
- **WAIT_RDY:** when `deser_ready`=1, set `rx_byte`<=`deser_data` and pulse `done[owner]` in the same cycle. Go to `ACK`.
- **ACK:** `deser_ack`=1 for exactly one cycle. Go to `DRAIN`.
- **DRAIN:** wait for `deser_ready`=0, then go to `IDLE`.
- A requester dropping `req` before its `gnt` withdraws the request; no error is raised.
- `req` still high in the cycle after `gnt` counts as a new request. With other requesters pending, round-robin moves past that requester.
- `req` changes during a transfer affect only the next arbitration.
- Out-of-range `req` bits (none with legal `N_REQ`) are ignored.

## Timing
- All outputs are registered.
- Reset values: `gnt`=0, `done`=0, `rx_byte`=0x00, `ser_data`=0, `ser_write`=0, `deser_ack`=0, `busy`=0, `err`=0. State resets to `IDLE`.
- With `req` high at edge E0 in `IDLE`:
  - `gnt` is high in cycle E0+1.
  - The first `ser_write` pulse is in cycle E0+2.
  - Pulses repeat every 2 cycles; the 8th pulse is in cycle E0+16.
  - `WAIT_RDY` starts in cycle E0+18.
- Each bit is presented as `ser_write` high for one cycle, then low for one cycle. `ser_data` is stable during both cycles.
- From `deser_ready` rise to `done`: 1 cycle. `deser_ack` follows `done` by 1 cycle.
- Minimum byte-to-byte spacing is 21 cycles, reached when `deser_ready` is already high on entry to `WAIT_RDY` and drops immediately after ack.
- Reset asserted mid-transfer forces all outputs to their reset values immediately (asynchronous) and aborts the byte. No `done` is issued. The deserializer must be reset in the same cycle.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- **Defined:** a counter clears on entry to `WAIT_RDY` and increments each cycle there. If it reaches `TIMEOUT_CYC` with `deser_ready` still 0:
  - pulse `err` for one cycle;
  - pulse `deser_ack` for one cycle to flush the deserializer;
  - go to `IDLE`;
  - issue no `done`. `rx_byte` is unchanged.
- **Undefined:** no counter. `WAIT_RDY` waits indefinitely and `err` is constant 0.

## Test plan
- Reset, then `req`=01 with `req_data[7:0]`=0xAD → `gnt`=01 at E0+1. `ser_data` at the 8 `ser_write` pulses is 1,0,1,0,1,1,0,1. Deserializer asserts `data_ready` → `rx_byte`=0xAD, `done`=01, then one `deser_ack` pulse.
- `req`=11 held, with data 0x3C (requester 0) and 0xC3 (requester 1) → grant order 0,1,0,1. `rx_byte` alternates 0x3C, 0xC3.
- `N_REQ`=4, `req`=1010 after requester 1 was served last → requester 3 wins, then 1.
- Withdrawal: `req`=01 and `req`=10 both high; drop requester 1's `req` during requester 0's `SHIFT` → only requester 0 gets `gnt`; `busy` falls after `DRAIN`.
- Assert `reset` at the 4th `ser_write` pulse → all outputs 0 in the same cycle. A following request for 0x5A completes with `rx_byte`=0x5A.
- With `ARB_TIMEOUT_EN` and `TIMEOUT_CYC`=8, hold `deser_ready`=0 → `err` pulses 8 cycles after `WAIT_RDY` entry, together with one `deser_ack` pulse; no `done`, `rx_byte` unchanged. Without the macro → `busy` stays high and `err`=0.
